me_window_scheduler: RTL and testbench

- Frame-level sequencer for the motion-estimation search engine.
- When a new frame is ready, it runs the search engine once per estimation window (NUM_WIN runs per frame), giving it a window limit and the 2-bit frame index.
- Generates the engine's start pulse, waits for its finish, and tracks frame and window indices.
- Flags frame overruns and engine hangs to the HPS.

---
 rtl/me_window_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_me_window_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/me_window_scheduler.sv
// me_window_scheduler
// Frame-level sequencer for the motion-estimation search engine. For each
// accepted frame it launches NUM_WIN engine runs, supplies the window limit
// and 2-bit frame index, waits for each finish, and reports frame overruns
// and engine hangs.

module me_window_scheduler #(
  parameter int MSBI    = 13,
  parameter int NUM_WIN = 10,
  parameter int TO_W    = 24
) (
  input  logic            clk_fsm,
  input  logic            rst,
  input  logic            enable,
  input  logic            frame_ready,
  input  logic [MSBI:0]   win_limit_cfg,
  input  logic [TO_W-1:0] timeout_cfg,
  input  logic            clr_err,
  input  logic            me_finish,
  input  logic            me_idle,
  output logic            me_start,
  output logic [MSBI:0]   window_limit,
  output logic [1:0]      cont_img,
  output logic [3:0]      win_idx,
  output logic            busy,
  output logic            frame_done,
  output logic            overrun,
  output logic            timeout_err,
  output logic [2:0]      sched_state
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_FRAME = 3'd1,
    S_ARM        = 3'd2,
    S_START      = 3'd3,
    S_RUN        = 3'd4,
    S_NEXT_WIN   = 3'd5,
    S_FRAME_DONE = 3'd6,
    S_ERROR      = 3'd7
  } state_t;

  localparam logic [3:0]      LAST_WIN = 4'(NUM_WIN - 1);
  localparam logic [TO_W-1:0] TO_MAX   = {TO_W{1'b1}};

  state_t          state;
  state_t          state_nxt;
  logic            pending;
  logic [TO_W-1:0] to_cnt;

  logic frame_go;
  logic to_hit;
  logic last_win;
  logic err_clear;

  // A frame is accepted from WAIT_FRAME either directly or from the pending flag
  assign frame_go  = (state == S_WAIT_FRAME) && enable && (frame_ready || pending);
  assign to_hit    = (timeout_cfg != '0) && (to_cnt == (timeout_cfg - TO_W'(1)));
  assign last_win  = (win_idx == LAST_WIN);
  assign err_clear = (state == S_ERROR) && clr_err;

  // State register
  always_ff @(posedge clk_fsm) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; enable is only looked at in IDLE, WAIT_FRAME, FRAME_DONE
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (enable) state_nxt = S_WAIT_FRAME;
      end
      S_WAIT_FRAME: begin
        if (!enable)      state_nxt = S_IDLE;
        else if (frame_go) state_nxt = S_ARM;
      end
      S_ARM: begin
        if (me_idle) state_nxt = S_START;
      end
      S_START: begin
        state_nxt = S_RUN;
      end
      S_RUN: begin
        if (me_finish)   state_nxt = S_NEXT_WIN;
        else if (to_hit) state_nxt = S_ERROR;
      end
      S_NEXT_WIN: begin
        state_nxt = last_win ? S_FRAME_DONE : S_ARM;
      end
      S_FRAME_DONE: begin
        state_nxt = enable ? S_WAIT_FRAME : S_IDLE;
      end
      S_ERROR: begin
        if (clr_err) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Pending frame flag: a frame that arrives while not waiting for one
  always_ff @(posedge clk_fsm) begin
    if (rst) begin
      pending <= 1'b0;
    end else if (err_clear) begin
      pending <= 1'b0;
    end else if (state == S_WAIT_FRAME) begin
      if (frame_go) pending <= 1'b0;
    end else if (frame_ready) begin
      pending <= 1'b1;
    end
  end

  // Sticky overrun: a second frame while one is already pending
  always_ff @(posedge clk_fsm) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (err_clear) begin
      overrun <= 1'b0;
    end else if (frame_ready && pending && (state != S_WAIT_FRAME)) begin
      overrun <= 1'b1;
    end else if (clr_err) begin
      overrun <= 1'b0;
    end
  end

  // Run-length counter: counts cycles since the start pulse, saturating at all ones
  always_ff @(posedge clk_fsm) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state == S_ARM) begin
      to_cnt <= '0;
    end else if ((state == S_START) || (state == S_RUN)) begin
      if (to_cnt != TO_MAX) to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // Sticky hang flag; a finish in the same cycle as the limit wins
  always_ff @(posedge clk_fsm) begin
    if (rst) begin
      timeout_err <= 1'b0;
    end else if (err_clear) begin
      timeout_err <= 1'b0;
    end else if ((state == S_RUN) && !me_finish && to_hit) begin
      timeout_err <= 1'b1;
    end
  end

  // Frame busy: set on accept, dropped at frame end or on leaving ERROR
  always_ff @(posedge clk_fsm) begin
    if (rst) begin
      busy <= 1'b0;
    end else if (frame_go) begin
      busy <= 1'b1;
    end else if ((state == S_FRAME_DONE) || err_clear) begin
      busy <= 1'b0;
    end
  end

  // Window limit is frozen at frame accept so mid-frame config changes are ignored
  always_ff @(posedge clk_fsm) begin
    if (rst) begin
      window_limit <= '0;
    end else if (frame_go) begin
      window_limit <= win_limit_cfg;
    end
  end

  // Window index: restarts at accept, advances after each non-final window
  always_ff @(posedge clk_fsm) begin
    if (rst) begin
      win_idx <= '0;
    end else if (frame_go) begin
      win_idx <= '0;
    end else if ((state == S_NEXT_WIN) && !last_win) begin
      win_idx <= win_idx + 4'd1;
    end
  end

  // Frame index advances mod 4 only on a completed frame
  always_ff @(posedge clk_fsm) begin
    if (rst) begin
      cont_img <= '0;
    end else if (state == S_FRAME_DONE) begin
      cont_img <= cont_img + 2'd1;
    end
  end

  assign me_start    = (state == S_START);
  assign frame_done  = (state == S_FRAME_DONE);
  assign sched_state = state;

endmodule

// File: tb/tb_me_window_scheduler.sv
// tb_me_window_scheduler
// Directed bench for me_window_scheduler with a simple search-engine model
// that drops idle on each start and returns a finish a set number of cycles later.

module tb_me_window_scheduler;

  localparam int MSBI    = 13;
  localparam int NUM_WIN = 10;
  localparam int TO_W    = 24;

  logic            clk_fsm = 1'b0;
  logic            rst = 1'b1;
  logic            enable = 1'b0;
  logic            frame_ready = 1'b0;
  logic [MSBI:0]   win_limit_cfg = '0;
  logic [TO_W-1:0] timeout_cfg = '0;
  logic            clr_err = 1'b0;
  logic            me_finish = 1'b0;
  logic            me_idle;
  logic            me_start;
  logic [MSBI:0]   window_limit;
  logic [1:0]      cont_img;
  logic [3:0]      win_idx;
  logic            busy;
  logic            frame_done;
  logic            overrun;
  logic            timeout_err;
  logic [2:0]      sched_state;

  logic eng_idle = 1'b1;
  logic hold_low = 1'b0;
  int   eng_delay = 50;

  assign me_idle = eng_idle & ~hold_low;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int         st_cyc[$];
  logic [3:0] st_win[$];
  logic [MSBI:0] st_wl[$];
  logic [1:0] st_img[$];
  int         dn_cyc[$];
  logic [1:0] dn_img[$];
  logic       done_d = 1'b0;

  me_window_scheduler #(.MSBI(MSBI), .NUM_WIN(NUM_WIN), .TO_W(TO_W)) dut (
    .clk_fsm      (clk_fsm),
    .rst          (rst),
    .enable       (enable),
    .frame_ready  (frame_ready),
    .win_limit_cfg(win_limit_cfg),
    .timeout_cfg  (timeout_cfg),
    .clr_err      (clr_err),
    .me_finish    (me_finish),
    .me_idle      (me_idle),
    .me_start     (me_start),
    .window_limit (window_limit),
    .cont_img     (cont_img),
    .win_idx      (win_idx),
    .busy         (busy),
    .frame_done   (frame_done),
    .overrun      (overrun),
    .timeout_err  (timeout_err),
    .sched_state  (sched_state)
  );

  always #5 clk_fsm = ~clk_fsm;

  // Cycle index: value during cycle k equals k
  always @(posedge clk_fsm) cyc <= cyc + 1;

  // Record every start pulse and the frame index just after each frame_done
  always @(negedge clk_fsm) begin
    if (me_start) begin
      st_cyc.push_back(cyc);
      st_win.push_back(win_idx);
      st_wl.push_back(window_limit);
      st_img.push_back(cont_img);
    end
    if (done_d) dn_img.push_back(cont_img);
    if (frame_done) dn_cyc.push_back(cyc);
    done_d = frame_done;
  end

  // Search-engine model; eng_delay==0 means it never finishes
  initial begin
    forever begin
      @(negedge clk_fsm);
      if (me_start && !rst) begin
        eng_idle = 1'b0;
        if (eng_delay == 0) begin
          while (!(rst || sched_state == 3'd0)) @(negedge clk_fsm);
        end else begin
          for (int k = 0; k < eng_delay && !rst; k++) @(negedge clk_fsm);
          if (!rst) begin
            me_finish = 1'b1;
            @(negedge clk_fsm);
            me_finish = 1'b0;
          end
        end
        eng_idle = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_fsm);
  endtask

  task automatic pulse_fr(output int c);
    frame_ready = 1'b1;
    c = cyc;
    @(negedge clk_fsm);
    frame_ready = 1'b0;
  endtask

  task automatic wait_starts(input int n, input int budget, input string tag);
    int k = 0;
    while (st_cyc.size() < n && k < budget) begin tick(1); k++; end
    chk(tag, 32'(st_cyc.size() >= n), 1);
  endtask

  task automatic wait_done(input int n, input int budget, input string tag);
    int k = 0;
    while (dn_cyc.size() < n && k < budget) begin tick(1); k++; end
    chk(tag, 32'(dn_cyc.size() >= n), 1);
  endtask

  task automatic wait_win(input logic [3:0] w, input int budget, input string tag);
    int k = 0;
    while (!(sched_state == 3'd4 && win_idx == w) && k < budget) begin tick(1); k++; end
    chk(tag, 32'(sched_state == 3'd4 && win_idx == w), 1);
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({me_start, window_limit, cont_img, win_idx, busy, frame_done,
                overrun, timeout_err, sched_state});
  endfunction

  initial begin
    int fr;
    int s0;
    int s1;
    int d0;
    int k;
    logic [1:0] img0;
    logic [1:0] exp_img [5];
    exp_img = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    // Reset state
    tick(3);
    chk("reset_outputs", all_outs(), 0);
    rst = 1'b0;
    enable = 1'b1;
    win_limit_cfg = 14'd400;
    timeout_cfg = '0;
    eng_delay = 50;
    tick(2);
    chk("idle_to_wait", 32'(sched_state), 1);
    chk("no_start_after_reset", 32'(st_cyc.size()), 0);

    // Nominal frame
    pulse_fr(fr);
    wait_starts(1, 10, "first_start_wait");
    chk("frame_to_start_latency", 32'(st_cyc[0] - fr), 2);
    chk("busy_in_frame", 32'(busy), 1);
    wait_starts(5, 400, "start5_wait");
    enable = 1'b0;
    win_limit_cfg = 14'd123;
    wait_starts(8, 400, "start8_wait");
    enable = 1'b1;
    wait_done(1, 800, "frame0_done_wait");
    tick(2);
    chk("nominal_start_count", 32'(st_cyc.size()), 10);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("win_idx_%0d", i), 32'(st_win[i]), 32'(i));
      chk($sformatf("window_limit_%0d", i), 32'(st_wl[i]), 400);
    end
    chk("finish_to_start_spacing", 32'(st_cyc[1] - st_cyc[0]), 53);
    chk("last_start_to_done", 32'(dn_cyc[0] - st_cyc[9]), 52);
    chk("cont_img_after_frame0", 32'(cont_img), 1);
    chk("busy_after_frame", 32'(busy), 0);
    chk("wait_after_done", 32'(sched_state), 1);

    // cont_img wrap across back-to-back frames
    eng_delay = 5;
    for (int f = 1; f < 5; f++) begin
      pulse_fr(fr);
      wait_done(f + 1, 300, $sformatf("wrap_done_%0d", f));
    end
    tick(2);
    chk("wrap_done_count", 32'(dn_img.size()), 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("cont_img_seq_%0d", i), 32'(dn_img[i]), 32'(exp_img[i]));

    // Overrun: two extra frames during window 3
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    eng_delay = 20;
    tick(2);
    s0 = st_cyc.size();
    d0 = dn_cyc.size();
    pulse_fr(fr);
    wait_win(4'd3, 400, "overrun_win3_wait");
    pulse_fr(fr);
    tick(1);
    chk("overrun_after_first", 32'(overrun), 0);
    pulse_fr(fr);
    chk("overrun_after_second", 32'(overrun), 1);
    wait_done(d0 + 1, 600, "overrun_frame0_done");
    wait_starts(s0 + 11, 10, "overrun_frame1_start");
    chk("pending_frame_gap", 32'(st_cyc[s0 + 10] - dn_cyc[d0]), 3);
    wait_done(d0 + 2, 600, "overrun_frame1_done");
    tick(100);
    chk("no_third_frame", 32'(st_cyc.size() - s0), 20);
    chk("overrun_sticky", 32'(overrun), 1);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    chk("overrun_cleared_outside_error", 32'(overrun), 0);
    chk("clr_err_no_state_change", 32'(sched_state), 1);

    // Timeout: engine never finishes
    timeout_cfg = 24'd100;
    eng_delay = 0;
    img0 = cont_img;
    s0 = st_cyc.size();
    pulse_fr(fr);
    wait_starts(s0 + 1, 10, "timeout_start_wait");
    k = 0;
    while (!timeout_err && k < 300) begin tick(1); k++; end
    chk("timeout_latency", 32'(cyc - st_cyc[s0]), 100);
    chk("error_state", 32'(sched_state), 7);
    chk("error_busy", 32'(busy), 1);
    tick(30);
    chk("no_start_in_error", 32'(st_cyc.size()), 32'(s0 + 1));
    chk("error_holds_win_idx", 32'(win_idx), 0);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    chk("clr_err_to_idle", 32'(sched_state), 0);
    chk("timeout_err_cleared", 32'(timeout_err), 0);
    chk("busy_cleared", 32'(busy), 0);
    chk("cont_img_unchanged", 32'(cont_img), 32'(img0));

    // Race: finish in the cycle the counter reaches the limit
    eng_delay = 99;
    tick(2);
    s0 = st_cyc.size();
    d0 = dn_cyc.size();
    pulse_fr(fr);
    wait_starts(s0 + 2, 300, "race_second_start");
    chk("race_next_win", 32'(st_win[s0 + 1]), 1);
    chk("race_spacing", 32'(st_cyc[s0 + 1] - st_cyc[s0]), 102);
    chk("race_no_timeout", 32'(timeout_err), 0);
    wait_done(d0 + 1, 1500, "race_frame_done");
    chk("race_frame_no_timeout", 32'(timeout_err), 0);

    // Handshake: me_idle held low while armed
    timeout_cfg = '0;
    eng_delay = 10;
    tick(2);
    hold_low = 1'b1;
    s0 = st_cyc.size();
    pulse_fr(fr);
    tick(19);
    chk("armed_waits_idle", 32'(sched_state), 2);
    chk("no_start_while_busy_engine", 32'(st_cyc.size()), 32'(s0));
    hold_low = 1'b0;
    wait_starts(s0 + 1, 10, "handshake_start_wait");
    chk("handshake_start_cycle", 32'(st_cyc[s0] - fr), 21);

    // Reset mid-run in window 5
    wait_win(4'd5, 400, "reset_win5_wait");
    rst = 1'b1;
    tick(1);
    chk("midrun_reset_outputs", all_outs(), 0);
    tick(1);
    rst = 1'b0;
    s1 = st_cyc.size();
    tick(2);
    chk("no_start_after_midrun_reset", 32'(st_cyc.size()), 32'(s1));
    pulse_fr(fr);
    wait_starts(s1 + 1, 10, "restart_start_wait");
    chk("restart_win_idx", 32'(st_win[s1]), 0);
    chk("restart_cont_img", 32'(st_img[s1]), 0);
    chk("restart_latency", 32'(st_cyc[s1] - fr), 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
